// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package rv_fetch_pkg;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_RUN   = 2'd1,
    FS_DRAIN = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; used for prefetched words and in-order request PCs.
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output T                       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  T              mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    pop_ok_s  = pop && (count_r != '0);
    push_ok_s = push && ((count_r != (AW+1)'(DEPTH)) || pop_ok_s);
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == '0);
  assign full  = (count_r == (AW+1)'(DEPTH));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, imem req/rsp handshake, prefetch FIFO, redirect flush/drain.
// Optional IFU_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state_r;
  logic [31:0]   pc_r;
  logic [CW-1:0] inflight_r;
  logic [CW-1:0] drop_cnt_r;
  logic [CW-1:0] inflight_next_s;
  logic [CW-1:0] occupancy_s;
  logic          req_fire_s;
  logic          rsp_keep_s;
  logic          rsp_drop_s;
  logic          pop_s;

  fetch_entry_t  data_head_s;
  logic [CW-1:0] data_count_s;
  logic          data_empty_s;
  logic          data_full_s;
  logic [31:0]   tag_head_s;
  logic [CW-1:0] tag_count_s;
  logic          tag_empty_s;
  logic          tag_full_s;
  logic          unused_s;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) u_data_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep_s),
    .push_data ('{pc: tag_head_s, instr: imem_rsp_data}),
    .pop       (pop_s),
    .flush     (redirect_valid),
    .head      (data_head_s),
    .count     (data_count_s),
    .empty     (data_empty_s),
    .full      (data_full_s)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(logic [31:0])) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire_s),
    .push_data (pc_r),
    .pop       (rsp_keep_s),
    .flush     (redirect_valid),
    .head      (tag_head_s),
    .count     (tag_count_s),
    .empty     (tag_empty_s),
    .full      (tag_full_s)
  );

  // Issue gating counts in-flight plus buffered words so every response has a FIFO slot.
  always_comb begin
    occupancy_s = inflight_r + data_count_s;
    if (state_r == FS_RUN) begin
      imem_req_valid = !redirect_valid && (occupancy_s < CW'(FIFO_DEPTH)) && !data_full_s;
    end else begin
      imem_req_valid = 1'b0;
    end
    imem_req_addr = pc_r;
    req_fire_s    = imem_req_valid && imem_req_ready;
    rsp_keep_s    = imem_rsp_valid && (drop_cnt_r == '0) && !redirect_valid;
    rsp_drop_s    = imem_rsp_valid && !rsp_keep_s;
    pop_s         = !data_empty_s && instr_ready && !redirect_valid;
    case ({req_fire_s, imem_rsp_valid})
      2'b10:   inflight_next_s = inflight_r + CW'(1);
      2'b01:   inflight_next_s = inflight_r - CW'(1);
      default: inflight_next_s = inflight_r;
    endcase
  end

  // Decode side sees the FIFO head; zero while empty.
  always_comb begin
    instr_valid = !data_empty_s;
    if (data_empty_s) begin
      instr    = 32'h0000_0000;
      instr_pc = 32'h0000_0000;
    end else begin
      instr    = data_head_s.instr;
      instr_pc = data_head_s.pc;
    end
  end

  // Fetch FSM, PC and in-flight bookkeeping; a redirect always takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= FS_BOOT;
      pc_r       <= RESET_PC;
      inflight_r <= '0;
      drop_cnt_r <= '0;
    end else begin
      inflight_r <= inflight_next_s;
      if (redirect_valid) begin
        pc_r       <= {redirect_pc[31:2], 2'b00};
        drop_cnt_r <= inflight_next_s;
        state_r    <= (inflight_next_s != '0) ? FS_DRAIN : FS_RUN;
      end else begin
        if (req_fire_s) pc_r <= pc_r + 32'(INSTR_BYTES);
        if (rsp_drop_s) drop_cnt_r <= drop_cnt_r - CW'(1);
        case (state_r)
          FS_BOOT:  state_r <= FS_RUN;
          FS_RUN:   state_r <= FS_RUN;
          FS_DRAIN: begin
            if ((drop_cnt_r == '0) || (rsp_drop_s && (drop_cnt_r == CW'(1)))) state_r <= FS_RUN;
            else state_r <= FS_DRAIN;
          end
          default:  state_r <= FS_BOOT;
        endcase
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Fetched = FIFO pushes; flushed = entries cleared by redirect plus discarded responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'h0000_0000;
      perf_flushed <= 32'h0000_0000;
    end else begin
      perf_fetched <= perf_fetched + (rsp_keep_s ? 32'd1 : 32'd0);
      perf_flushed <= perf_flushed + (redirect_valid ? 32'(data_count_s) : 32'd0)
                                   + (rsp_drop_s ? 32'd1 : 32'd0);
    end
  end
`endif

  assign unused_s = ^{redirect_pc[1:0], tag_count_s, tag_empty_s, tag_full_s};

endmodule
